// File: rtl/hazard_flush_unit_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, controller states and the load opcode.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LU  = 2'd1,
        ST_MW  = 2'd2
    } state_t;

    localparam logic [3:0] LOAD_OPC = 4'b0100;

endpackage

// File: rtl/hazard_flush_unit_if.sv
// Bundle between the 5-stage pipeline datapath (master) and the hazard/flush controller (slave).
interface hazard_flush_unit_if #(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int OPC_W      = 4,
    parameter int CNT_W      = 16
);
    logic [NUM_SRC*REG_ADDR_W-1:0] rr_src_addr;
    logic [NUM_SRC-1:0]            rr_src_used;
    logic [OPC_W-1:0]              ex_opcode;
    logic [REG_ADDR_W-1:0]         ex_rd_addr;
    logic                          ex_rd_we;
    logic [REG_ADDR_W-1:0]         mem_rd_addr;
    logic                          mem_rd_we;
    logic                          mem_is_access;
    logic                          mem_ready;
    logic [REG_ADDR_W-1:0]         wb_rd_addr;
    logic                          wb_rd_we;
    logic                          redirect;

    logic [NUM_SRC*2-1:0]          fwd_sel;
    logic                          pc_en;
    logic                          if_id_en;
    logic                          id_ex_en;
    logic                          ex_mem_en;
    logic                          if_id_flush;
    logic                          id_ex_flush;
    logic                          mem_wb_flush;
    logic                          pc_sel;
    logic                          mem_timeout;
    logic [CNT_W-1:0]              stall_cnt;
    logic [CNT_W-1:0]              flush_cnt;

    modport master (
        output rr_src_addr, rr_src_used, ex_opcode, ex_rd_addr, ex_rd_we,
               mem_rd_addr, mem_rd_we, mem_is_access, mem_ready,
               wb_rd_addr, wb_rd_we, redirect,
        input  fwd_sel, pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_flush, pc_sel,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rr_src_addr, rr_src_used, ex_opcode, ex_rd_addr, ex_rd_we,
               mem_rd_addr, mem_rd_we, mem_is_access, mem_ready,
               wb_rd_addr, wb_rd_we, redirect,
        output fwd_sel, pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_flush, pc_sel,
               mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_flush_unit_fwd_select.sv
// Per-source forwarding select: youngest matching writer wins (EX > MEM > WB > register file).
module fwd_select #(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_we,
    output logic [1:0]            sel
);
    import pipe_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (src_used) begin
            if (ex_rd_we && (ex_rd_addr == src_addr)) begin
                sel = FWD_EX;
            end else if (mem_rd_we && (mem_rd_addr == src_addr)) begin
                sel = FWD_MEM;
            end else if (wb_rd_we && (wb_rd_addr == src_addr)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_flush_unit.sv
// Hazard and forwarding controller: forwarding selects, stage enables/flushes, PC redirect,
// data-memory wait with sticky timeout, and saturating stall/flush counters.
module hazard_flush_unit #(
    parameter int               REG_ADDR_W  = 3,
    parameter int               NUM_SRC     = 2,
    parameter int               OPC_W       = 4,
    parameter logic [OPC_W-1:0] LOAD_OPC    = pipe_pkg::LOAD_OPC,
    parameter int               MEM_TIMEOUT = 15,
    parameter int               CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_flush_unit_if.slave bus
);
    import pipe_pkg::*;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_wait(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;
    logic                timeout_flag, timeout_hit;
    logic                stall_inc, flush_inc;
    logic [NUM_SRC*2-1:0] fwd_raw;
    logic [NUM_SRC-1:0]  lu_src;
    logic                lu, mw;
    logic                pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic                if_id_flush, id_ex_flush, mem_wb_flush, pc_sel;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_ADDR_W-1:0] addr;
        assign addr = bus.rr_src_addr[i*REG_ADDR_W +: REG_ADDR_W];

        fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
            .src_addr    (addr),
            .src_used    (bus.rr_src_used[i]),
            .ex_rd_addr  (bus.ex_rd_addr),
            .ex_rd_we    (bus.ex_rd_we),
            .mem_rd_addr (bus.mem_rd_addr),
            .mem_rd_we   (bus.mem_rd_we),
            .wb_rd_addr  (bus.wb_rd_addr),
            .wb_rd_we    (bus.wb_rd_we),
            .sel         (fwd_raw[2*i +: 2])
        );

        assign lu_src[i] = bus.rr_src_used[i] && (addr == bus.ex_rd_addr);
    end

    assign lu = (bus.ex_opcode == LOAD_OPC) && bus.ex_rd_we && (|lu_src);
    assign mw = bus.mem_is_access && !bus.mem_ready;

    // Wait counter only runs while the access is stalled; the timeout fires on the cycle it reaches the limit.
    assign wait_next   = mw ? sat_wait(wait_cnt) : '0;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mw && (int'(wait_next) >= MEM_TIMEOUT);

    always_comb begin
        state_next   = state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        pc_sel       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!reset) begin
            if (mw) begin
                state_next   = ST_MW;
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
                stall_inc    = 1'b1;
            end else begin
                state_next = ST_RUN;
                // Release cycle out of a memory wait is a clean restart; held redirects act next cycle.
                if (state != ST_MW) begin
                    if (bus.redirect) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (lu && (state == ST_RUN)) begin
                        state_next  = ST_LU;
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (stall_inc) stall_cnt <= sat_cnt(stall_cnt);
            if (flush_inc) flush_cnt <= sat_cnt(flush_cnt);
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end

    // The load has moved to MEM during the bubble, so a second load-use here means a pipeline bug.
    assert property (@(posedge clk) disable iff (reset) (state == ST_LU) |-> !lu);

    assign bus.fwd_sel      = reset ? '0 : fwd_raw;
    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.pc_sel       = pc_sel;
    assign bus.mem_timeout  = timeout_flag;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Directed bench for hazard_flush_unit: forwarding priority, load-use bubble, redirect, memory wait, timeout, async reset.
module tb_hazard_flush_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_flush_unit_if bus ();

    hazard_flush_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] en4();
        return {28'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en};
    endfunction

    function automatic logic [31:0] fl3();
        return {29'd0, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
    endfunction

    task automatic idle();
        bus.rr_src_addr   = '0;
        bus.rr_src_used   = '0;
        bus.ex_opcode     = 4'b0000;
        bus.ex_rd_addr    = '0;
        bus.ex_rd_we      = 1'b0;
        bus.mem_rd_addr   = '0;
        bus.mem_rd_we     = 1'b0;
        bus.mem_is_access = 1'b0;
        bus.mem_ready     = 1'b1;
        bus.wb_rd_addr    = '0;
        bus.wb_rd_we      = 1'b0;
        bus.redirect      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset with hazard-causing inputs: outputs must be forced to pass-through.
        reset = 1'b1;
        idle();
        bus.ex_opcode     = 4'b0100;
        bus.ex_rd_addr    = 3'd1;
        bus.ex_rd_we      = 1'b1;
        bus.rr_src_addr   = {3'd0, 3'd1};
        bus.rr_src_used   = 2'b01;
        bus.mem_is_access = 1'b1;
        bus.mem_ready     = 1'b0;
        tick();
        chk("rst_en", en4(), 32'hF);
        chk("rst_fl", fl3(), 32'h0);
        chk("rst_pcsel", 32'(bus.pc_sel), 32'h0);
        chk("rst_fwd", 32'(bus.fwd_sel), 32'h0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'h0);
        chk("rst_flush", 32'(bus.flush_cnt), 32'h0);
        chk("rst_tmo", 32'(bus.mem_timeout), 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b0;

        // Test 1: forwarding priority. src0 = R3, src1 = R3 but unused.
        tick();
        bus.ex_opcode   = 4'b0000;
        bus.ex_rd_addr  = 3'd3;
        bus.ex_rd_we    = 1'b1;
        bus.rr_src_addr = {3'd3, 3'd3};
        bus.rr_src_used = 2'b01;
        #1;
        chk("fwd_ex", 32'(bus.fwd_sel), 32'h1);
        chk("fwd_ex_en", en4(), 32'hF);
        bus.mem_rd_addr = 3'd3;
        bus.mem_rd_we   = 1'b1;
        bus.wb_rd_addr  = 3'd3;
        bus.wb_rd_we    = 1'b1;
        #1;
        chk("fwd_ex_wins", 32'(bus.fwd_sel), 32'h1);
        bus.ex_rd_we = 1'b0;
        #1;
        chk("fwd_mem", 32'(bus.fwd_sel), 32'h2);
        bus.mem_rd_we = 1'b0;
        #1;
        chk("fwd_wb", 32'(bus.fwd_sel), 32'h3);
        // Both used: src0 = R0 from WB, src1 = R5 from MEM (addresses differ from EX destination)
        bus.rr_src_addr = {3'd5, 3'd0};
        bus.rr_src_used = 2'b11;
        bus.wb_rd_addr  = 3'd0;
        bus.wb_rd_we    = 1'b1;
        bus.mem_rd_addr = 3'd5;
        bus.mem_rd_we   = 1'b1;
        #1;
        chk("fwd_r0_mix", 32'(bus.fwd_sel), 32'h b);

        // Test 2: load-use on src1 (R2).
        tick();
        idle();
        bus.ex_opcode   = 4'b0100;
        bus.ex_rd_addr  = 3'd2;
        bus.ex_rd_we    = 1'b1;
        bus.rr_src_addr = {3'd2, 3'd6};
        bus.rr_src_used = 2'b11;
        #1;
        chk("lu_en", en4(), 32'h3);
        chk("lu_fl", fl3(), 32'h2);
        chk("lu_pcsel", 32'(bus.pc_sel), 32'h0);
        tick();
        bus.ex_opcode   = 4'b0000;
        bus.ex_rd_we    = 1'b0;
        bus.mem_rd_addr = 3'd2;
        bus.mem_rd_we   = 1'b1;
        #1;
        chk("lu_next_fwd", 32'(bus.fwd_sel), 32'h8);
        chk("lu_next_en", en4(), 32'hF);
        chk("lu_next_fl", fl3(), 32'h0);
        chk("lu_stall", 32'(bus.stall_cnt), 32'h1);

        // Test 3: redirect with a coincident load-use.
        tick();
        idle();
        bus.ex_opcode   = 4'b0100;
        bus.ex_rd_addr  = 3'd2;
        bus.ex_rd_we    = 1'b1;
        bus.rr_src_addr = {3'd0, 3'd2};
        bus.rr_src_used = 2'b01;
        bus.redirect    = 1'b1;
        #1;
        chk("rd_pcsel", 32'(bus.pc_sel), 32'h1);
        chk("rd_fl", fl3(), 32'h6);
        chk("rd_en", en4(), 32'hF);
        tick();
        idle();
        #1;
        chk("rd_flush_cnt", 32'(bus.flush_cnt), 32'h1);
        chk("rd_no_bubble", 32'(bus.stall_cnt), 32'h1);
        chk("rd_after_en", en4(), 32'hF);

        // Test 4: three wait cycles then ready; redirect during the wait is not acted on.
        pulse_reset();
        bus.mem_is_access = 1'b1;
        bus.mem_ready     = 1'b0;
        bus.redirect      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_en", en4(), 32'h0);
            chk("mw_fl", fl3(), 32'h1);
            chk("mw_pcsel", 32'(bus.pc_sel), 32'h0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.redirect  = 1'b0;
        #1;
        chk("mw_rel_en", en4(), 32'hF);
        chk("mw_rel_fl", fl3(), 32'h0);
        chk("mw_stall", 32'(bus.stall_cnt), 32'h3);
        chk("mw_flush_cnt", 32'(bus.flush_cnt), 32'h0);
        tick();
        bus.mem_is_access = 1'b0;
        #1;
        chk("mw_stall_hold", 32'(bus.stall_cnt), 32'h3);

        // Test 5: 16 wait cycles against a limit of 15.
        pulse_reset();
        bus.mem_is_access = 1'b1;
        bus.mem_ready     = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 14) chk("tmo_14", 32'(bus.mem_timeout), 32'h0);
            if (k == 15) chk("tmo_15", 32'(bus.mem_timeout), 32'h1);
            if (k == 16) chk("tmo_16", 32'(bus.mem_timeout), 32'h1);
        end
        chk("tmo_stall", 32'(bus.stall_cnt), 32'd16);
        bus.mem_ready = 1'b1;
        #1;
        chk("tmo_rel_en", en4(), 32'hF);
        tick();
        bus.mem_is_access = 1'b0;
        tick();
        chk("tmo_sticky", 32'(bus.mem_timeout), 32'h1);

        // Test 6: asynchronous reset in the middle of a wait.
        bus.mem_is_access = 1'b1;
        bus.mem_ready     = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_stall", 32'(bus.stall_cnt), 32'h0);
        chk("arst_flush", 32'(bus.flush_cnt), 32'h0);
        chk("arst_tmo", 32'(bus.mem_timeout), 32'h0);
        chk("arst_en", en4(), 32'hF);
        chk("arst_fl", fl3(), 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b0;
        tick();
        chk("arst_after_en", en4(), 32'hF);
        chk("arst_after_stall", 32'(bus.stall_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
